// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: streams two latched operands LSB-first through one full_adder.
// Optional zero-result flag output enabled by defining SERIAL_ADD_SUB_ZERO_FLAG_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic cout_c
);

  assign sum_c  = a ^ b ^ cin;
  assign cout_c = (a & b) | (cin & (a ^ b));

endmodule

module serial_add_sub #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             fa_sum_c;
  logic             fa_cout_c;
  logic [WIDTH-1:0] result_nx_c;

  full_adder u_fa (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .cin    (carry),
    .sum_c  (fa_sum_c),
    .cout_c (fa_cout_c)
  );

  // Sum bit enters at the MSB so bit i settles at result[i] after WIDTH shifts.
  assign result_nx_c = (result >> 1) | (WIDTH'(fa_sum_c) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
      zero      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction becomes A + ~B + 1 via inverted B and carry-in of 1.
            a_sh     <= a;
            b_sh     <= b ^ {WIDTH{sub}};
            carry    <= sub;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          result <= result_nx_c;
          carry  <= fa_cout_c;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            overflow  <= carry ^ fa_cout_c;
            cout      <= fa_cout_c;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
            zero      <= (result_nx_c == '0);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed table, random vs arithmetic model,
// backpressure and mid-operation reset sequences.

module tb_serial_add_sub;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic, modulo 2^W.
  function automatic void model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub,
                                output logic [W-1:0] r, output logic c, output logic o,
                                output logic z);
    int ua, ub, sa, sb, s;
    ua = int'(va);
    ub = int'(vb);
    sa = int'($signed(va));
    sb = int'($signed(vb));
    if (vsub) begin
      r = W'(ua - ub);
      c = (ua >= ub);
      s = sa - sb;
    end else begin
      r = W'(ua + ub);
      c = ((ua + ub) >= (1 << W));
      s = sa + sb;
    end
    o = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
    z = (r == '0);
  endfunction

  task automatic check_outputs(input string tag, input logic [W-1:0] er, input logic ec,
                               input logic eo, input logic ez);
    chk({tag, " result"}, 32'(result), 32'(er));
    chk({tag, " cout"}, 32'(cout), 32'(ec));
    chk({tag, " overflow"}, 32'(overflow), 32'(eo));
`ifdef SERIAL_ADD_SUB_ZERO_FLAG_EN
    chk({tag, " zero"}, 32'(zero), 32'(ez));
`else
    if (ez === 1'bx) $display("zero flag expectation undefined for %s", tag);
`endif
  endtask

  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vsub,
                        input logic [W-1:0] er, input logic ec, input logic eo,
                        input logic ez, input string tag);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a = va; b = vb; sub = vsub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " in_ready run"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 3 * W + 4) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(W));
    check_outputs(tag, er, ec, eo, ez);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
    chk({tag, " in_ready back"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[8];

  initial begin
    logic [W-1:0] ra, rb, er;
    logic         rs, ec, eo, ez;
    int           lat;

    vecs[0] = '{a: 4'd3,  b: 4'd5, sub: 1'b0, r: 4'd8,  c: 1'b0, o: 1'b1, z: 1'b0};
    vecs[1] = '{a: 4'd7,  b: 4'd2, sub: 1'b1, r: 4'd5,  c: 1'b1, o: 1'b0, z: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd1, sub: 1'b1, r: 4'd15, c: 1'b0, o: 1'b0, z: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd1, sub: 1'b0, r: 4'd0,  c: 1'b1, o: 1'b0, z: 1'b1};
    vecs[4] = '{a: 4'd8,  b: 4'd1, sub: 1'b1, r: 4'd7,  c: 1'b1, o: 1'b1, z: 1'b0};
    vecs[5] = '{a: 4'd4,  b: 4'd4, sub: 1'b0, r: 4'd8,  c: 1'b0, o: 1'b1, z: 1'b0};
    vecs[6] = '{a: 4'd8,  b: 4'd8, sub: 1'b0, r: 4'd0,  c: 1'b1, o: 1'b1, z: 1'b1};
    vecs[7] = '{a: 4'd5,  b: 4'd5, sub: 1'b1, r: 4'd0,  c: 1'b1, o: 1'b0, z: 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    check_outputs("reset", '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, er, ec, eo, ez);
      run_op(ra, rb, rs, er, ec, eo, ez, $sformatf("rnd%0d", i));
    end

    // Backpressure with stray in_valid while busy.
    @(negedge clk);
    a = 4'd9; b = 4'd4; sub = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    a = 4'd1; b = 4'd1; sub = 1'b0;
    chk("bp in_ready run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 3 * W + 4) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", 32'(lat), 32'(W));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp out_valid hold", 32'(out_valid), 32'd1);
      chk("bp in_ready hold", 32'(in_ready), 32'd0);
      check_outputs("bp hold", 4'd5, 1'b1, 1'b1, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp out_valid drop", 32'(out_valid), 32'd0);
    chk("bp in_ready back", 32'(in_ready), 32'd1);
    check_outputs("bp held after", 4'd5, 1'b1, 1'b1, 1'b0);

    // Reset two cycles into RUN of 6+6.
    @(negedge clk);
    a = 4'd6; b = 4'd6; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    check_outputs("midrst", '0, 1'b0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    chk("midrst no pulse", 32'(out_valid), 32'd0);
    run_op(4'd6, 4'd1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
